// File: rtl/mojo_serial_rx_pkg.sv
// Shared 8N1 framing constants and receiver state encoding.
// Also intended for the matching transmitter.
package mojo_serial_rx_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/mojo_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input pin.
// RST_VAL sets the value both flops take during reset.
module mojo_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mojo_serial_rx.sv
// 8N1 UART receiver, mid-bit sampling, byte + one-cycle strobe out.
// A low stop bit raises frame_error and waits for the line to go high.
module mojo_serial_rx
    import mojo_serial_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       frame_error
);

    localparam int CTR_W = $clog2(CLK_PER_BIT);
    localparam logic [CTR_W-1:0] CTR_MAX  = CTR_W'(CLK_PER_BIT - 1);
    localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic w_rx_s;

    rx_state_e        r_state, w_state;
    logic [CTR_W-1:0] r_ctr, w_ctr;
    logic [2:0]       r_bit_idx, w_bit_idx;
    logic [7:0]       r_shift, w_shift;
    logic [7:0]       r_data, w_data;
    logic             r_new, w_new;
    logic             r_ferr, w_ferr;

    mojo_sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync (
        .i_clk  (clk),
        .i_rst_n(rst),
        .i_d    (rx),
        .o_q    (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ctr     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_new     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ctr     <= w_ctr;
            r_bit_idx <= w_bit_idx;
            r_shift   <= w_shift;
            r_data    <= w_data;
            r_new     <= w_new;
            r_ferr    <= w_ferr;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_ctr     = r_ctr;
        w_bit_idx = r_bit_idx;
        w_shift   = r_shift;
        w_data    = r_data;
        w_new     = 1'b0;
        w_ferr    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ctr = '0;
                if (!w_rx_s) w_state = ST_START;
            end
            ST_START: begin
                if (r_ctr == CTR_HALF) begin
                    w_ctr     = '0;
                    w_bit_idx = '0;
                    w_state   = w_rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    w_ctr = r_ctr + 1'b1;
                end
            end
            ST_DATA: begin
                if (r_ctr == CTR_MAX) begin
                    w_shift[r_bit_idx] = w_rx_s;
                    w_ctr     = '0;
                    w_bit_idx = r_bit_idx + 1'b1;
                    if (r_bit_idx == LAST_BIT) w_state = ST_STOP;
                end else begin
                    w_ctr = r_ctr + 1'b1;
                end
            end
            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is caught.
                if (r_ctr == CTR_MAX) begin
                    w_ctr = '0;
                    if (w_rx_s == STOP_LEVEL) begin
                        w_data  = r_shift;
                        w_new   = 1'b1;
                        w_state = ST_IDLE;
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = ST_BREAK;
                    end
                end else begin
                    w_ctr = r_ctr + 1'b1;
                end
            end
            ST_BREAK: begin
                w_ctr = '0;
                if (w_rx_s) w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
                w_ctr   = '0;
            end
        endcase
    end

    assign rx_data     = r_data;
    assign new_rx_data = r_new;
    assign frame_error = r_ferr;

endmodule

// File: tb/tb_mojo_serial_rx.sv
// Self-checking bench: directed frames plus random bytes vs a queue model.
// Second instance at 50 clocks/bit feeds a 2-byte block assembler model.
module tb_mojo_serial_rx;

    logic       clk;
    logic       rst;
    logic       rx8;
    logic       rx50;
    logic [7:0] rx_data8;
    logic [7:0] rx_data50;
    logic       new8;
    logic       new50;
    logic       ferr8;
    logic       ferr50;

    int checks;
    int errors;
    int cyc;

    logic [7:0] q_data[$];
    int         q_cyc[$];
    int         q_ferr[$];
    int         fall_q[$];
    logic [7:0] exp_q[$];

    logic [7:0]  blk_hi;
    logic        blk_half;
    logic [15:0] blk;
    int          blk_n;
    int          ferr50_n;

    mojo_serial_rx #(.CLK_PER_BIT(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx8),
        .rx_data    (rx_data8),
        .new_rx_data(new8),
        .frame_error(ferr8)
    );

    mojo_serial_rx #(.CLK_PER_BIT(50)) dut50 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx50),
        .rx_data    (rx_data50),
        .new_rx_data(new50),
        .frame_error(ferr50)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        checks++;
        assert (!(new8 && ferr8)) else begin
            errors++;
            $error("FAIL excl new=%0b ferr=%0b required not both", new8, ferr8);
        end
        if (new8) begin
            q_data.push_back(rx_data8);
            q_cyc.push_back(cyc);
        end
        if (ferr8) q_ferr.push_back(cyc);
        if (ferr50) ferr50_n++;
        if (new50) begin
            if (!blk_half) begin
                blk_hi   = rx_data50;
                blk_half = 1'b1;
            end else begin
                blk      = {blk_hi, rx_data50};
                blk_n++;
                blk_half = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int obs, input int exp);
        checks++;
        assert (obs >= exp - 1 && obs <= exp + 1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+-1", tag, obs, exp);
        end
    endtask

    function automatic int pred(input int fall, input int cpb);
        return fall + 2 + cpb / 2 + 9 * cpb + 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop,
                        input bit big);
        int         cpb;
        logic [9:0] fr;
        cpb = big ? 50 : 8;
        fr  = {stop, b, 1'b0};
        if (!big) fall_q.push_back(cyc);
        for (int i = 0; i < 10; i++) begin
            if (big) rx50 = fr[i];
            else     rx8  = fr[i];
            tick(cpb);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_cyc.delete();
        q_ferr.delete();
        fall_q.delete();
        exp_q.delete();
    endtask

    task automatic check_rx(input string tag);
        int n;
        chk({tag, " count"}, q_data.size(), exp_q.size());
        n = (q_data.size() < exp_q.size()) ? q_data.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " data"}, q_data[i], exp_q[i]);
            chk_lat({tag, " lat"}, q_cyc[i], pred(fall_q[i], 8));
        end
        chk({tag, " ferr"}, q_ferr.size(), 0);
        if (exp_q.size() > 0) chk({tag, " hold"}, rx_data8, exp_q[$]);
        clear_q();
    endtask

    initial begin
        logic [7:0] b;
        int         gap;
        checks   = 0;
        errors   = 0;
        blk_half = 1'b0;
        blk_hi   = '0;
        blk      = '0;
        blk_n    = 0;
        ferr50_n = 0;
        rx8      = 1'b1;
        rx50     = 1'b1;
        rst      = 1'b0;
        tick(3);
        chk("rst data", rx_data8, 8'h00);
        chk("rst new", new8, 1'b0);
        chk("rst ferr", ferr8, 1'b0);
        chk("rst data50", rx_data50, 8'h00);
        rst = 1'b1;
        clear_q();
        tick(100);
        check_rx("idle");

        send(8'h55, 1'b1, 1'b0);
        send(8'hA5, 1'b1, 1'b0);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hA5);
        tick(30);
        check_rx("b2b");

        rx8 = 1'b0;
        tick(2);
        rx8 = 1'b1;
        tick(20);
        check_rx("glitch");
        send(8'h3C, 1'b1, 1'b0);
        exp_q.push_back(8'h3C);
        tick(30);
        check_rx("post glitch");

        send(8'h81, 1'b0, 1'b0);
        tick(40);
        rx8 = 1'b1;
        tick(30);
        chk("ferr count", q_ferr.size(), 1);
        if (q_ferr.size() > 0)
            chk_lat("ferr lat", q_ferr[0], pred(fall_q[0], 8));
        chk("ferr no new", q_data.size(), 0);
        chk("ferr hold", rx_data8, 8'h3C);
        clear_q();
        send(8'h7E, 1'b1, 1'b0);
        exp_q.push_back(8'h7E);
        tick(30);
        check_rx("post break");

        fork
            send(8'hF0, 1'b1, 1'b0);
            begin
                tick(5 * 8 + 4);
                rst = 1'b0;
                tick(2);
                rst = 1'b1;
            end
        join
        tick(30);
        chk("midrst new", q_data.size(), 0);
        chk("midrst ferr", q_ferr.size(), 0);
        chk("midrst data", rx_data8, 8'h00);
        clear_q();
        send(8'h0F, 1'b1, 1'b0);
        exp_q.push_back(8'h0F);
        tick(30);
        check_rx("post midrst");

        for (int i = 0; i < 12; i++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 3);
            send(b, 1'b1, 1'b0);
            exp_q.push_back(b);
            tick(gap + 1);
        end
        tick(30);
        check_rx("random");

        send(8'h12, 1'b1, 1'b1);
        send(8'h34, 1'b1, 1'b1);
        tick(100);
        chk("blk strobes", blk_n, 1);
        chk("blk value", blk, 16'h1234);
        chk("blk ferr", ferr50_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
